// File: rtl/prom_5600_arbiter.sv
// prom_5600_arbiter
//   Lets two requesters share one 32x8 bipolar PROM (part_5600). An arbiter
//   picks a winner and drives the PROM address and active-low chip enable. It
//   then waits out the PROM access time, captures the byte, and returns it to
//   the winner with a one-cycle acknowledge. Every output is registered.
//
//   Build option: define PROM_ARB_RR_EN to get round-robin tie-breaking.
//   Without it, requester 0 always wins a tie (fixed priority).
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst_n     asynchronous reset, active low
//   req0      requester 0 read request, held until ack0
//   addr0     requester 0 PROM address, stable while req0 is high
//   ack0      one-cycle pulse: rdata is valid for requester 0
//   req1      requester 1 read request, held until ack1
//   addr1     requester 1 PROM address, stable while req1 is high
//   ack1      one-cycle pulse: rdata is valid for requester 1
//   rdata     last captured PROM byte, held until the next capture
//   grant     requester currently or most recently served
//   busy      high while an access is in flight (ACCESS and DONE)
//   rom_a     PROM address A4..A0
//   rom_ce_n  PROM chip enable, active low
//   rom_d     PROM data O7..O0 (reads all ones when rom_ce_n is high)

module prom_5600_arbiter #(
  parameter int WAIT_CYC = 2,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              ack0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              grant,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_a,
  output logic              rom_ce_n,
  input  logic [DATA_W-1:0] rom_d
);

  localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             pick1;
  logic             granted_req;

`ifdef PROM_ARB_RR_EN
  // rr_ptr names the requester that wins the next tie. It is 0 after reset and
  // flips to the other requester only when an access completes.
  logic rr_ptr;
`endif

  // Choose the winner for a new access. When only one request is present it
  // always wins; the tie-break rule matters only when both are high.
  always_comb begin
    pick1 = 1'b0;
`ifdef PROM_ARB_RR_EN
    pick1 = req1 & (~req0 | rr_ptr);
`else
    pick1 = req1 & ~req0;
`endif
  end

  // The access is aborted if the requester it is serving lets go of its request.
  assign granted_req = grant ? req1 : req0;

  // Main sequencer. IDLE starts an access. ACCESS holds the PROM enabled until
  // the wait counter runs out. DONE is the single cycle in which the ACK is high.
  // Reset takes effect immediately, even mid-access, so an interrupted read
  // never produces an ACK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rom_a    <= '0;
      rom_ce_n <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= '0;
      grant    <= 1'b0;
      busy     <= 1'b0;
`ifdef PROM_ARB_RR_EN
      rr_ptr   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          ack0 <= 1'b0;
          ack1 <= 1'b0;
          if (req0 || req1) begin
            grant    <= pick1;
            rom_a    <= pick1 ? addr1 : addr0;
            rom_ce_n <= 1'b0;
            wait_cnt <= CNT_W'(WAIT_CYC - 1);
            busy     <= 1'b1;
            state    <= ACCESS;
          end
        end

        ACCESS: begin
          if (!granted_req) begin
            rom_ce_n <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (wait_cnt == '0) begin
            // Sample the PROM only now, while it is still enabled.
            rdata    <= rom_d;
            rom_ce_n <= 1'b1;
            ack0     <= ~grant;
            ack1     <= grant;
            state    <= DONE;
`ifdef PROM_ARB_RR_EN
            rr_ptr   <= ~grant;
`endif
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        DONE: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          rom_ce_n <= 1'b1;
          ack0     <= 1'b0;
          ack1     <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prom_5600_arbiter.sv
// tb_prom_5600_arbiter
//   Bench for prom_5600_arbiter. It holds a behavioural model of the PROM.
//   Whenever a request is raised, the byte that request should return goes
//   into a queue for that requester. A monitor pops the entry on every ACK and
//   compares it with rdata. A second instance built with WAIT_CYC=1 covers
//   the back-to-back throughput case.

module tb_prom_5600_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [4:0] addr0, addr1;
  logic       ack0, ack1;
  logic [7:0] rdata;
  logic       grant, busy;
  logic [4:0] rom_a;
  logic       rom_ce_n;
  logic [7:0] rom_d;

  logic       w_req0;
  logic [4:0] w_addr0;
  logic       w_req1;
  logic [4:0] w_addr1;
  logic       w_ack0, w_ack1;
  logic [7:0] w_rdata;
  logic       w_grant, w_busy;
  logic [4:0] w_rom_a;
  logic       w_rom_ce_n;
  logic [7:0] w_rom_d;

  logic [7:0] prom [32];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] model_rdata;

  int n_cmp;
  int n_bad;

  // The PROM drives weak ones onto its outputs whenever it is disabled.
  assign rom_d   = rom_ce_n   ? 8'hFF : prom[rom_a];
  assign w_rom_d = w_rom_ce_n ? 8'hFF : prom[w_rom_a];

  prom_5600_arbiter #(.WAIT_CYC(2), .ADDR_W(5), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .ack0(ack0),
    .req1(req1), .addr1(addr1), .ack1(ack1),
    .rdata(rdata), .grant(grant), .busy(busy),
    .rom_a(rom_a), .rom_ce_n(rom_ce_n), .rom_d(rom_d)
  );

  prom_5600_arbiter #(.WAIT_CYC(1), .ADDR_W(5), .DATA_W(8)) dut_w1 (
    .clk(clk), .rst_n(rst_n),
    .req0(w_req0), .addr0(w_addr0), .ack0(w_ack0),
    .req1(w_req1), .addr1(w_addr1), .ack1(w_ack1),
    .rdata(w_rdata), .grant(w_grant), .busy(w_busy),
    .rom_a(w_rom_a), .rom_ce_n(w_rom_ce_n), .rom_d(w_rom_d)
  );

  // Free-running clock. Rising edges fall at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input int id, input logic v);
    if (id == 0) req0 = v;
    else         req1 = v;
  endtask

  task automatic set_addr(input int id, input logic [4:0] a);
    if (id == 0) addr0 = a;
    else         addr1 = a;
  endtask

  task automatic push_expected(input int id, input logic [4:0] a);
    if (id == 0) q0.push_back(prom[a]);
    else         q1.push_back(prom[a]);
  endtask

  task automatic drop_expected(input int id);
    if (id == 0) q0.delete();
    else         q1.delete();
  endtask

  // Waits a bounded number of cycles for either ACK. Returns -1 on timeout.
  task automatic wait_ack(output int who);
    who = -1;
    for (int i = 0; i < 30 && who < 0; i++) begin
      tick();
      if (ack0)      who = 0;
      else if (ack1) who = 1;
    end
    if (who < 0) checkOutput("ack_timeout", 32'd0, 32'd1);
  endtask

  // A random requester agent. It raises requests at random addresses and
  // holds each one until its ACK arrives. Once in a while it gives up early.
  task automatic applyStimulus(input int id, input int ncyc);
    bit         pending;
    int         waited;
    int         abort_at;
    logic [4:0] a;
    logic       my_ack;
    pending  = 1'b0;
    waited   = 0;
    abort_at = -1;
    for (int c = 0; c < ncyc; c++) begin
      tick();
      my_ack = (id == 0) ? ack0 : ack1;
      if (pending) begin
        if (my_ack) begin
          set_req(id, 1'b0);
          pending = 1'b0;
        end else begin
          waited++;
          if (waited == abort_at) begin
            set_req(id, 1'b0);
            drop_expected(id);
            pending = 1'b0;
          end else if (waited > 300) begin
            checkOutput("req_timeout", waited, 32'd300);
            set_req(id, 1'b0);
            drop_expected(id);
            pending = 1'b0;
          end
        end
      end else if ($urandom_range(2) == 0) begin
        a = 5'($urandom);
        push_expected(id, a);
        set_addr(id, a);
        set_req(id, 1'b1);
        pending  = 1'b1;
        waited   = 0;
        abort_at = ($urandom_range(7) == 0) ? int'($urandom_range(6, 1)) : -1;
      end
    end
    if (pending) begin
      set_req(id, 1'b0);
      drop_expected(id);
    end
  endtask

  // Scoreboard monitor: every ACK must match the oldest expected byte for
  // that requester, and the two ACKs must never be high together.
  initial begin
    logic [7:0] expv;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        checkOutput("ack_exclusive", {31'b0, ack0 & ack1}, 32'd0);
        if (ack0) begin
          if (q0.size() == 0) checkOutput("ack0_expected", q0.size(), 32'd1);
          else begin
            expv = q0.pop_front();
            checkOutput("ack0_data", rdata, expv);
            checkOutput("ack0_grant", grant, 32'd0);
            model_rdata = expv;
          end
        end
        if (ack1) begin
          if (q1.size() == 0) checkOutput("ack1_expected", q1.size(), 32'd1);
          else begin
            expv = q1.pop_front();
            checkOutput("ack1_data", rdata, expv);
            checkOutput("ack1_grant", grant, 32'd1);
            model_rdata = expv;
          end
        end
      end
    end
  end

  // Directed scenarios first, then the long random run.
  initial begin
    int who;
    int last_cyc;
    int cyc;
    n_cmp = 0;
    n_bad = 0;
    model_rdata = 8'h00;
    for (int i = 0; i < 32; i++) prom[i] = 8'($urandom);
    prom[0]  = 8'hC3;
    prom[1]  = 8'h11;
    prom[2]  = 8'h22;
    prom[3]  = 8'hA5;
    prom[31] = 8'h5A;

    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    w_req0 = 1'b0; w_req1 = 1'b0; w_addr0 = 5'd0; w_addr1 = 5'd0;
    repeat (2) tick();
    checkOutput("rst_ce_n",  rom_ce_n, 32'd1);
    checkOutput("rst_rom_a", rom_a, 32'd0);
    checkOutput("rst_acks",  {ack0, ack1}, 32'd0);
    checkOutput("rst_rdata", rdata, 32'd0);
    checkOutput("rst_grant", grant, 32'd0);
    checkOutput("rst_busy",  busy, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single read of address 3: the PROM is enabled for two clocks, then the ACK.
    push_expected(0, 5'd3);
    addr0 = 5'd3; req0 = 1'b1;
    tick();
    checkOutput("t1_ce_low_1", rom_ce_n, 32'd0);
    checkOutput("t1_rom_a", rom_a, 32'd3);
    checkOutput("t1_busy", busy, 32'd1);
    tick();
    checkOutput("t1_ce_low_2", rom_ce_n, 32'd0);
    checkOutput("t1_no_ack_yet", ack0, 32'd0);
    tick();
    checkOutput("t1_ack0", ack0, 32'd1);
    checkOutput("t1_rdata", rdata, 32'hA5);
    checkOutput("t1_ce_high", rom_ce_n, 32'd1);
    req0 = 1'b0;
    tick();
    checkOutput("t1_ack_one_cycle", ack0, 32'd0);
    checkOutput("t1_busy_off", busy, 32'd0);

    // Tie: both requesters at once. Requester 0 re-raises right after its ACK.
    push_expected(0, 5'd1);
    push_expected(1, 5'd2);
    addr0 = 5'd1; addr1 = 5'd2; req0 = 1'b1; req1 = 1'b1;
    wait_ack(who);
    checkOutput("tie1_first", who, 32'd0);
    req0 = 1'b0;
    tick();
    push_expected(0, 5'd1);
    req0 = 1'b1;
    wait_ack(who);
`ifdef PROM_ARB_RR_EN
    checkOutput("tie2_first", who, 32'd1);
`else
    checkOutput("tie2_first", who, 32'd0);
`endif
    if (who == 0) req0 = 1'b0;
    else if (who == 1) req1 = 1'b0;
    wait_ack(who);
`ifdef PROM_ARB_RR_EN
    checkOutput("tie2_second", who, 32'd0);
`else
    checkOutput("tie2_second", who, 32'd1);
`endif
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) tick();

    // Abort: requester 1 lets go during its first access clock.
    addr1 = 5'h1F; req1 = 1'b1;
    tick();
    checkOutput("ab_ce_low", rom_ce_n, 32'd0);
    req1 = 1'b0;
    tick();
    checkOutput("ab_ce_high", rom_ce_n, 32'd1);
    checkOutput("ab_no_ack", ack1, 32'd0);
    checkOutput("ab_rdata_kept", rdata, model_rdata);
    checkOutput("ab_busy_off", busy, 32'd0);
    tick();
    checkOutput("ab_no_late_ack", ack1, 32'd0);

    // Reset arriving mid-access clears the outputs at once.
    addr0 = 5'd3; req0 = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mr_ce_n", rom_ce_n, 32'd1);
    checkOutput("mr_acks", {ack0, ack1}, 32'd0);
    checkOutput("mr_rdata", rdata, 32'd0);
    checkOutput("mr_busy", busy, 32'd0);
    model_rdata = 8'h00;
    q0.delete(); q1.delete();
    req0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // WAIT_CYC=1 instance: with the request held, an ACK comes every 3 clocks.
    w_addr0 = 5'd0; w_req0 = 1'b1;
    cyc = 0; last_cyc = -1;
    for (int k = 0; k < 4; k++) begin
      who = -1;
      for (int i = 0; i < 10 && who < 0; i++) begin
        tick();
        cyc++;
        if (w_ack0) who = 0;
      end
      checkOutput("w1_ack_seen", who, 32'd0);
      checkOutput("w1_rdata", w_rdata, 32'hC3);
      if (k > 0) checkOutput("w1_period", cyc - last_cyc, 32'd3);
      last_cyc = cyc;
    end
    w_req0 = 1'b0;
    repeat (3) tick();

    // Random traffic from both requesters at once.
    fork
      applyStimulus(0, 10000);
      applyStimulus(1, 10000);
    join
    repeat (6) tick();
    checkOutput("drain_q0", q0.size(), 32'd0);
    checkOutput("drain_q1", q1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
